// File: rtl/snake_control_if.sv
// Snake controller <-> datapath bundle: status in, control strobes out.
// master: controller side; slave: datapath side.
interface snake_control_if;
    logic [10:0] length;
    logic        isDead;
    logic        waiting;
    logic        ld_head;
    logic        ld_q_def;
    logic        inc_address;
    logic        rst_address;
    logic        draw_q;
    logic        update_head;
    logic        ld_head_into_prev;
    logic        ld_q_into_curr;
    logic        ld_prev_into_q;
    logic        ld_curr_into_prev;
    logic        draw_curr;
    logic        food_en;
    logic [1:0]  cnt_status;
    logic [2:0]  dir;
    logic [2:0]  colour;
    logic        dead;

    modport master (
        input  length, isDead,
        output waiting, ld_head, ld_q_def, inc_address, rst_address,
        output draw_q, update_head, ld_head_into_prev, ld_q_into_curr,
        output ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en,
        output cnt_status, dir, colour, dead
    );

    modport slave (
        output length, isDead,
        input  waiting, ld_head, ld_q_def, inc_address, rst_address,
        input  draw_q, update_head, ld_head_into_prev, ld_q_into_curr,
        input  ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en,
        input  cnt_status, dir, colour, dead
    );
endinterface

// File: rtl/snake_control.sv
// Snake frame sequencer: init, erase, move, shift, redraw, food, wait.
// Ports: clk, rst (async active-low), key_* pulses, dp (datapath bundle).
module snake_control #(
    parameter int         FRAME_CYCLES = 833333,
    parameter logic [2:0] BODY_COLOUR  = 3'b010,
    parameter logic [2:0] FOOD_COLOUR  = 3'b100
) (
    input  logic clk,
    input  logic rst,
    input  logic key_up,
    input  logic key_down,
    input  logic key_left,
    input  logic key_right,
    snake_control_if.master dp
);
    typedef enum logic [4:0] {
        INIT_HEAD, INIT_BODY, INIT_RST,
        ERASE_RD, ERASE_PIX, ERASE_NXT,
        MOVE, MOVE_PREV,
        SHIFT_RD, SHIFT_LD, SHIFT_WR, SHIFT_NXT,
        DRAW_RD, DRAW_PIX, DRAW_NXT,
        FOOD, WAIT, DEAD
    } state_t;

    localparam logic [2:0] DIR_RIGHT = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_DOWN  = 3'b110;
    localparam logic [2:0] DIR_UP    = 3'b100;
    localparam int FW = $clog2(FRAME_CYCLES + 1);

    state_t          state, next;
    logic [10:0]     seg_idx;
    logic [1:0]      pix;
    logic [FW-1:0]   frame_cnt;
    logic [2:0]      dir_q, want;
    logic            dead_q, set_dead, req, rev;
    logic            last_seg, pix_state;
    logic            c_wait, c_ld_head, c_ld_q_def, c_inc, c_rst_addr;
    logic            c_draw_q, c_upd, c_hp, c_qc, c_pq, c_cp, c_food;
    logic [2:0]      c_colour;

    assign last_seg  = (seg_idx == dp.length - 11'd1);
    assign pix_state = (state == ERASE_PIX) || (state == DRAW_PIX) ||
                       (state == FOOD);

    always_comb begin
        next       = state;
        set_dead   = 1'b0;
        c_wait     = 1'b0;
        c_ld_head  = 1'b0;
        c_ld_q_def = 1'b0;
        c_inc      = 1'b0;
        c_rst_addr = 1'b0;
        c_draw_q   = 1'b0;
        c_upd      = 1'b0;
        c_hp       = 1'b0;
        c_qc       = 1'b0;
        c_pq       = 1'b0;
        c_cp       = 1'b0;
        c_food     = 1'b0;
        c_colour   = 3'b000;
        unique case (state)
            INIT_HEAD: begin
                c_ld_head = 1'b1;
                next      = INIT_BODY;
            end
            INIT_BODY: begin
                c_ld_q_def = 1'b1;
                c_inc      = 1'b1;
                if (last_seg) next = INIT_RST;
            end
            INIT_RST: begin
                c_rst_addr = 1'b1;
                next       = ERASE_RD;
            end
            ERASE_RD: next = ERASE_PIX;
            ERASE_PIX: begin
                c_draw_q = 1'b1;
                if (pix == 2'd3) next = ERASE_NXT;
            end
            ERASE_NXT: begin
                if (last_seg) begin
                    c_rst_addr = 1'b1;
                    next       = MOVE;
                end else begin
                    c_inc = 1'b1;
                    next  = ERASE_RD;
                end
            end
            MOVE: begin
                c_upd = 1'b1;
                next  = MOVE_PREV;
            end
            MOVE_PREV: begin
                c_hp = 1'b1;
                next = SHIFT_RD;
            end
            SHIFT_RD: next = SHIFT_LD;
            SHIFT_LD: begin
                c_qc = 1'b1;
                next = SHIFT_WR;
            end
            SHIFT_WR: begin
                c_pq = 1'b1;
                c_cp = 1'b1;
                next = SHIFT_NXT;
            end
            SHIFT_NXT: begin
                if (last_seg) begin
                    c_rst_addr = 1'b1;
                    next       = DRAW_RD;
                end else begin
                    c_inc = 1'b1;
                    next  = SHIFT_RD;
                end
            end
            DRAW_RD: next = DRAW_PIX;
            DRAW_PIX: begin
                c_draw_q = 1'b1;
                c_colour = BODY_COLOUR;
                if (pix == 2'd3) begin
                    // the head (segment 0) cannot collide with itself
                    if (seg_idx != 11'd0 && dp.isDead) begin
                        set_dead = 1'b1;
                        next     = DEAD;
                    end else begin
                        next = DRAW_NXT;
                    end
                end
            end
            DRAW_NXT: begin
                if (last_seg) begin
                    c_rst_addr = 1'b1;
                    next       = FOOD;
                end else begin
                    c_inc = 1'b1;
                    next  = DRAW_RD;
                end
            end
            FOOD: begin
                c_food   = 1'b1;
                c_colour = FOOD_COLOUR;
                if (pix == 2'd3) next = WAIT;
            end
            WAIT: begin
                c_wait = 1'b1;
                if (frame_cnt == FW'(FRAME_CYCLES - 1)) next = ERASE_RD;
            end
            DEAD: next = DEAD;
            default: next = INIT_HEAD;
        endcase
    end

    always_comb begin
        want = dir_q;
        req  = 1'b1;
        if (key_up)         want = DIR_UP;
        else if (key_down)  want = DIR_DOWN;
        else if (key_left)  want = DIR_LEFT;
        else if (key_right) want = DIR_RIGHT;
        else                req  = 1'b0;
        rev = ((want == DIR_UP)    && (dir_q == DIR_DOWN))  ||
              ((want == DIR_DOWN)  && (dir_q == DIR_UP))    ||
              ((want == DIR_LEFT)  && (dir_q == DIR_RIGHT)) ||
              ((want == DIR_RIGHT) && (dir_q == DIR_LEFT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT_HEAD;
            seg_idx   <= 11'd0;
            pix       <= 2'd0;
            frame_cnt <= '0;
            dir_q     <= DIR_RIGHT;
            dead_q    <= 1'b0;
        end else begin
            state <= next;
            if (c_rst_addr)  seg_idx <= 11'd0;
            else if (c_inc)  seg_idx <= seg_idx + 11'd1;
            pix <= pix_state ? pix + 2'd1 : 2'd0;
            if (state == WAIT && next == WAIT) frame_cnt <= frame_cnt + 1'b1;
            else                               frame_cnt <= '0;
            if (set_dead) dead_q <= 1'b1;
            if (req && !rev && state != DEAD) dir_q <= want;
        end
    end

    // Strobes are forced low while reset is held, even though the
    // reset state itself decodes ld_head.
    assign dp.waiting           = c_wait & rst;
    assign dp.ld_head           = c_ld_head & rst;
    assign dp.ld_q_def          = c_ld_q_def & rst;
    assign dp.inc_address       = c_inc & rst;
    assign dp.rst_address       = c_rst_addr & rst;
    assign dp.draw_q            = c_draw_q & rst;
    assign dp.update_head       = c_upd & rst;
    assign dp.ld_head_into_prev = c_hp & rst;
    assign dp.ld_q_into_curr    = c_qc & rst;
    assign dp.ld_prev_into_q    = c_pq & rst;
    assign dp.ld_curr_into_prev = c_cp & rst;
    assign dp.draw_curr         = 1'b0;
    assign dp.food_en           = c_food & rst;
    assign dp.cnt_status        = (pix_state && rst) ? pix : 2'd0;
    assign dp.colour            = c_colour & {3{rst}};
    assign dp.dir               = dir_q;
    assign dp.dead              = dead_q;
endmodule

// File: tb/tb_snake_control.sv
// Self-checking bench for snake_control: frame scoreboard, key table,
// mid-walk reset and collision sequences.
module tb_snake_control;
    localparam int FC = 10;
    localparam int L  = 6;

    localparam logic [12:0] W  = 13'h1000;
    localparam logic [12:0] LH = 13'h0800;
    localparam logic [12:0] QD = 13'h0400;
    localparam logic [12:0] IN = 13'h0200;
    localparam logic [12:0] RA = 13'h0100;
    localparam logic [12:0] DQ = 13'h0080;
    localparam logic [12:0] UH = 13'h0040;
    localparam logic [12:0] HP = 13'h0020;
    localparam logic [12:0] QC = 13'h0010;
    localparam logic [12:0] PQ = 13'h0008;
    localparam logic [12:0] CP = 13'h0004;
    localparam logic [12:0] FE = 13'h0001;

    typedef struct packed {
        logic [12:0] s;
        logic [1:0]  c;
        logic [2:0]  col;
    } exp_t;

    typedef struct packed {
        logic [3:0] keys;
        logic [2:0] dir;
    } dvec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ku, kd, kl, kr;
    logic [12:0] obs;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];
    dvec_t dv[11];

    snake_control_if dp();

    snake_control #(.FRAME_CYCLES(FC)) dut (
        .clk(clk),
        .rst(rst),
        .key_up(ku),
        .key_down(kd),
        .key_left(kl),
        .key_right(kr),
        .dp(dp)
    );

    always #5 clk = ~clk;

    assign obs = {dp.waiting, dp.ld_head, dp.ld_q_def, dp.inc_address,
                  dp.rst_address, dp.draw_q, dp.update_head,
                  dp.ld_head_into_prev, dp.ld_q_into_curr,
                  dp.ld_prev_into_q, dp.ld_curr_into_prev,
                  dp.draw_curr, dp.food_en};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [12:0] s, input logic [1:0] c,
                        input logic [2:0] col);
        exp_t e;
        e.s = s;
        e.c = c;
        e.col = col;
        sb.push_back(e);
    endtask

    task automatic push_pix_walk(input logic [2:0] col);
        for (int i = 0; i < L; i++) begin
            push(13'h0, 2'd0, 3'd0);
            for (int k = 0; k < 4; k++) push(DQ, 2'(k), col);
            push((i == L - 1) ? RA : IN, 2'd0, 3'd0);
        end
    endtask

    task automatic check_sb();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty at cycle %0d", cyc);
        end else begin
            e = sb.pop_front();
            if (obs !== e.s || dp.cnt_status !== e.c ||
                dp.colour !== e.col) begin
                errors++;
                $display("FAIL frame_cycle%0d: got s=%b c=%0d col=%b want s=%b c=%0d col=%b",
                         cyc, obs, dp.cnt_status, dp.colour, e.s, e.c, e.col);
            end
        end
        cyc++;
    endtask

    task automatic pulse(input logic [3:0] k);
        {ku, kd, kl, kr} = k;
        step();
        {ku, kd, kl, kr} = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seg;
        bit done;
        dv[0]  = '{4'b0010, 3'b001};
        dv[1]  = '{4'b1000, 3'b100};
        dv[2]  = '{4'b0100, 3'b100};
        dv[3]  = '{4'b0010, 3'b000};
        dv[4]  = '{4'b0001, 3'b000};
        dv[5]  = '{4'b0100, 3'b110};
        dv[6]  = '{4'b1000, 3'b110};
        dv[7]  = '{4'b0001, 3'b001};
        dv[8]  = '{4'b1010, 3'b100};
        dv[9]  = '{4'b0011, 3'b000};
        dv[10] = '{4'b1100, 3'b100};

        {ku, kd, kl, kr} = 4'b0000;
        dp.length = 11'(L);
        dp.isDead = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", 32'(obs), 32'h0);
        chk("rst_cnt", 32'(dp.cnt_status), 32'h0);
        chk("rst_colour", 32'(dp.colour), 32'h0);
        chk("rst_dir", 32'(dp.dir), 32'h1);
        chk("rst_dead", 32'(dp.dead), 32'h0);

        push(LH, 2'd0, 3'd0);
        for (int i = 0; i < L; i++) push(QD | IN, 2'd0, 3'd0);
        push(RA, 2'd0, 3'd0);
        push_pix_walk(3'b000);
        push(UH, 2'd0, 3'd0);
        push(HP, 2'd0, 3'd0);
        for (int i = 0; i < L; i++) begin
            push(13'h0, 2'd0, 3'd0);
            push(QC, 2'd0, 3'd0);
            push(PQ | CP, 2'd0, 3'd0);
            push((i == L - 1) ? RA : IN, 2'd0, 3'd0);
        end
        push_pix_walk(3'b010);
        for (int k = 0; k < 4; k++) push(FE, 2'(k), 3'b100);
        for (int i = 0; i < FC; i++) push(W, 2'd0, 3'd0);
        push(13'h0, 2'd0, 3'd0);

        rst = 1'b1;
        #1;
        check_sb();
        while (sb.size() > 0) begin
            step();
            check_sb();
        end
        chk("frame_dead", 32'(dp.dead), 32'h0);

        for (int i = 0; i < 11; i++) begin
            pulse(dv[i].keys);
            chk($sformatf("dir_vec%0d", i), 32'(dp.dir), 32'(dv[i].dir));
        end

        n = 0;
        while (!obs[3] && n < 300) begin
            step();
            n++;
        end
        chk("reach_shift_wr", 32'(n < 300), 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst_strobes", 32'(obs), 32'h0);
        chk("midrst_dir", 32'(dp.dir), 32'h1);
        chk("midrst_cnt", 32'(dp.cnt_status), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("restart_head", 32'(obs), 32'(LH));
        step();
        chk("restart_body", 32'(obs), 32'(QD | IN));

        n = 0;
        while (!obs[6] && n < 300) begin
            step();
            n++;
        end
        chk("reach_move", 32'(n < 300), 32'h1);
        seg = 0;
        done = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            step();
            n++;
            if (obs[7] && dp.colour == 3'b010 && dp.cnt_status == 2'd3) begin
                seg++;
                if (seg == 1) begin
                    dp.isDead = 1'b1;
                    step();
                    dp.isDead = 1'b0;
                    chk("seg0_ignored_dead", 32'(dp.dead), 32'h0);
                    chk("seg0_next_inc", 32'(obs), 32'(IN));
                end else if (seg == 3) begin
                    dp.isDead = 1'b1;
                    step();
                    dp.isDead = 1'b0;
                    chk("seg2_dead", 32'(dp.dead), 32'h1);
                    chk("seg2_strobes", 32'(obs), 32'h0);
                    done = 1'b1;
                end
            end
        end
        chk("reach_seg2", 32'(done), 32'h1);
        pulse(4'b0100);
        chk("dead_dir_frozen", 32'(dp.dir), 32'h1);
        repeat (20) step();
        chk("dead_hold_strobes", 32'(obs), 32'h0);
        chk("dead_hold_flag", 32'(dp.dead), 32'h1);
        chk("dead_hold_colour", 32'(dp.colour), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
